dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. Accepts one load/store request at a time over a valid/ready handshake and drives a word-wide, synchronous-read data RAM. Loads are returned as sign- or zero-extended lane data; sub-word stores are performed as read-modify-write. Sits between the MEM stage and the data RAM.

---
 rtl/dmem_responder.sv | 184 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time against a synchronous-read word RAM.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned LH/LHU/SH/LW/SW with rsp_err instead of executing.

`ifndef LB
`define LB  4'b0000
`endif
`ifndef LH
`define LH  4'b0001
`endif
`ifndef LW
`define LW  4'b0010
`endif
`ifndef LBU
`define LBU 4'b0100
`endif
`ifndef LHU
`define LHU 4'b0101
`endif
`ifndef SB
`define SB  4'b1000
`endif
`ifndef SH
`define SH  4'b1001
`endif
`ifndef SW
`define SW  4'b1010
`endif

module dmem_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_access,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_wdata
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic [3:0]  r_access;
  logic [15:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_wdata;
  logic        r_err;

  logic        w_accept, w_consume;
  logic        w_is_load, w_is_rmw, w_is_sw, w_misalign, w_cap_rmw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data, w_merge;

  assign w_accept  = req_valid & req_ready;
  assign w_consume = rsp_valid & rsp_ready;
  assign w_cap_rmw = (r_access == `SB) || (r_access == `SH);

  always_comb begin
    w_is_load = 1'b0;
    w_is_rmw  = 1'b0;
    w_is_sw   = 1'b0;
    case (req_access)
      `LB, `LBU, `LH, `LHU, `LW: w_is_load = 1'b1;
      `SB, `SH:                  w_is_rmw  = 1'b1;
      `SW:                       w_is_sw   = 1'b1;
      default: ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (req_access)
      `LH, `LHU, `SH: w_misalign = req_addr[0];
      `LW, `SW:       w_misalign = |req_addr[1:0];
      default: ;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Lane extraction and read-modify-write merge both work on the word returned in CAPTURE
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (r_access)
      `LB:     w_load_data = {{24{w_byte[7]}}, w_byte};
      `LBU:    w_load_data = {24'h000000, w_byte};
      `LH:     w_load_data = {{16{w_half[15]}}, w_half};
      `LHU:    w_load_data = {16'h0000, w_half};
      default: w_load_data = mem_rdata;
    endcase

    w_merge = mem_rdata;
    if (r_access == `SB) begin
      case (r_addr[1:0])
        2'd0:    w_merge[7:0]   = r_wdata[7:0];
        2'd1:    w_merge[15:8]  = r_wdata[7:0];
        2'd2:    w_merge[23:16] = r_wdata[7:0];
        default: w_merge[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_wdata;
    end else begin
      w_merge[15:0] = r_wdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misalign)                  w_next = S_RESP;
          else if (w_is_load || w_is_rmw)  w_next = S_READ;
          else if (w_is_sw)                w_next = S_WRITE;
          else                             w_next = S_RESP;
        end
      end
      S_READ:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = w_cap_rmw ? S_WRITE : S_RESP;
      S_WRITE:   w_next = S_RESP;
      S_RESP:    if (w_consume) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_access    <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= req_addr;
        r_access <= req_access;
        r_wdata  <= req_wdata[15:0];
        r_rdata  <= '0;
        r_err    <= w_misalign;
        if (w_is_sw && !w_misalign) r_mem_wdata <= req_wdata;
      end
      if (r_state == S_CAPTURE) begin
        if (w_cap_rmw) r_mem_wdata <= w_merge;
        else           r_rdata     <= w_load_data;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE)  & ~rst;
  assign rsp_valid = (r_state == S_RESP)  & ~rst;
  assign mem_ren   = (r_state == S_READ)  & ~rst;
  assign mem_wen   = (r_state == S_WRITE) & ~rst;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = r_mem_wdata;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expected responses/writes, monitor checks them.
// Build with DMEM_MISALIGN_TRAP_EN defined to exercise the misalignment trap.

module tb_dmem_responder;

  localparam logic [3:0] A_LB  = 4'b0000, A_LH  = 4'b0001, A_LW  = 4'b0010,
                         A_LBU = 4'b0100, A_LHU = 4'b0101, A_SB  = 4'b1000,
                         A_SH  = 4'b1001, A_SW  = 4'b1010, A_BAD = 4'b1111;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_access;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_ren, mem_wen;

  dmem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_access(req_access), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ram [0:255];
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_data;
  always @(posedge clk) begin
    if (ld_en) ram[ld_idx] <= ld_data;
    else if (mem_wen) ram[mem_addr[9:2]] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_addr[9:2]];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ren;
    int          wen;
    logic [31:0] maddr;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wq[$];
  int   n_cmp = 0, n_bad = 0, n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
  endtask

  // Monitor: pairs every RAM write and every consumed response with the queued expectation
  initial begin
    int   acc_cyc, first_lat, tx_ren, tx_wen;
    bit   prev_v;
    exp_t e;
    wr_t  w;
    acc_cyc = 0; first_lat = 0; tx_ren = 0; tx_wen = 0; prev_v = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_ren = 0; tx_wen = 0; first_lat = 0; prev_v = 0;
      end else begin
        if (mem_ren && mem_wen) fail("ren_wen_overlap");
        if (mem_ren) begin
          tx_ren++;
          if (exp_q.size() > 0) chk("ren_addr", mem_addr, exp_q[0].maddr);
        end
        if (mem_wen) begin
          tx_wen++;
          if (wq.size() == 0) fail("unexpected_write");
          else begin
            w = wq.pop_front();
            chk("wr_addr", mem_addr, w.addr);
            chk("wr_data", mem_wdata, w.data);
            chk("wr_lat", cyc - acc_cyc + 1, w.lat);
          end
        end
        if (rsp_valid && !prev_v) first_lat = cyc - acc_cyc + 1;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) fail("unexpected_response");
          else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            chk("rsp_lat", first_lat, e.lat);
            chk("ren_count", tx_ren, e.ren);
            chk("wen_count", tx_wen, e.wen);
          end
          n_done++;
        end
        prev_v = rsp_valid && !rsp_ready;
        if (req_valid && req_ready) begin
          acc_cyc = cyc + 1;
          tx_ren  = 0;
          tx_wen  = 0;
        end
      end
    end
  end

  task automatic load(input logic [7:0] idx, input logic [31:0] data);
    ld_idx = idx; ld_data = data; ld_en = 1'b1;
    @(posedge clk); #1 ld_en = 1'b0;
  endtask

  task automatic send(input logic [3:0] acc, input logic [31:0] addr, input logic [31:0] wd);
    bit ok;
    ok = 0;
    req_access = acc; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1 req_valid = 1'b0;
    if (!ok) fail("accept_timeout");
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (n_done >= target) begin ok = 1; break; end
    end
    #1;
    if (!ok) fail("response_timeout");
  endtask

  task automatic issue(input logic [3:0] acc, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic err, input int lat,
                       input int ren, input int wen, input logic [31:0] wdat, input int wlat);
    exp_t e;
    wr_t  w;
    int   d0;
    e.rdata = rd; e.err = err; e.lat = lat; e.ren = ren; e.wen = wen;
    e.maddr = {addr[31:2], 2'b00};
    exp_q.push_back(e);
    if (wen != 0) begin
      w.addr = {addr[31:2], 2'b00}; w.data = wdat; w.lat = wlat;
      wq.push_back(w);
    end
    d0 = n_done;
    send(acc, addr, wd);
    wait_done(d0 + 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_ren",   {31'b0, mem_ren}, 32'd0);
    chk("rst_mem_wen",   {31'b0, mem_wen}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0;
    bit  ok;
    exp_t e;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_access = '0; req_wdata = '0;
    rsp_ready = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    @(posedge clk); #1;
    load(8'h40, 32'h8899AABB);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b0;

    // acc, addr, wdata, rdata, err, lat, ren, wen, wdata-to-RAM, write latency
    issue(A_LB,  32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LBU, 32'h101, 32'h0, 32'h000000AA, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LB,  32'h102, 32'h0, 32'hFFFFFF99, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LBU, 32'h103, 32'h0, 32'h00000088, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LHU, 32'h102, 32'h0, 32'h00008899, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LH,  32'h102, 32'h0, 32'hFFFF8899, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LH,  32'h100, 32'h0, 32'hFFFFAABB, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LW,  32'h100, 32'h0, 32'h8899AABB, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_BAD, 32'h100, 32'h5, 32'h00000000, 1'b0, 1, 0, 0, 32'h0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    issue(A_LW,  32'h102, 32'h0, 32'h00000000, 1'b1, 1, 0, 0, 32'h0, 0);
    issue(A_LH,  32'h101, 32'h0, 32'h00000000, 1'b1, 1, 0, 0, 32'h0, 0);
    issue(A_LHU, 32'h103, 32'h0, 32'h00000000, 1'b1, 1, 0, 0, 32'h0, 0);
`else
    issue(A_LW,  32'h102, 32'h0, 32'h8899AABB, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LH,  32'h101, 32'h0, 32'hFFFFAABB, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LHU, 32'h103, 32'h0, 32'h00008899, 1'b0, 3, 1, 0, 32'h0, 0);
`endif
    issue(A_SB,  32'h103, 32'h00000012, 32'h0, 1'b0, 4, 1, 1, 32'h1299AABB, 3);
    issue(A_LW,  32'h100, 32'h0, 32'h1299AABB, 1'b0, 3, 1, 0, 32'h0, 0);
    load(8'h40, 32'h8899AABB);
    issue(A_SH,  32'h100, 32'hFFFF3456, 32'h0, 1'b0, 4, 1, 1, 32'h88993456, 3);
    issue(A_SH,  32'h102, 32'h0000BEEF, 32'h0, 1'b0, 4, 1, 1, 32'hBEEF3456, 3);
    issue(A_LW,  32'h100, 32'h0, 32'hBEEF3456, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_SW,  32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF, 1);
    issue(A_LW,  32'h104, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LH,  32'h106, 32'h0, 32'hFFFFDEAD, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_SB,  32'h105, 32'hFFFFFFAB, 32'h0, 1'b0, 4, 1, 1, 32'hDEADABEF, 3);
`ifdef DMEM_MISALIGN_TRAP_EN
    issue(A_SW,  32'h106, 32'h01020304, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
    issue(A_LW,  32'h104, 32'h0, 32'hDEADABEF, 1'b0, 3, 1, 0, 32'h0, 0);
`else
    issue(A_SW,  32'h106, 32'h01020304, 32'h0, 1'b0, 2, 0, 1, 32'h01020304, 1);
    issue(A_LW,  32'h104, 32'h0, 32'h01020304, 1'b0, 3, 1, 0, 32'h0, 0);
`endif

    // Back-pressure: response held 5 cycles while a second request waits
    rsp_ready = 1'b0;
    e.rdata = 32'hBEEF3456; e.err = 1'b0; e.lat = 3; e.ren = 1; e.wen = 0; e.maddr = 32'h100;
    exp_q.push_back(e);
    d0 = n_done;
    send(A_LW, 32'h100, 32'h0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) fail("stall_rsp_timeout");
    e.rdata = 32'h00000056; e.lat = 3; e.ren = 1; e.wen = 0; e.maddr = 32'h100;
    exp_q.push_back(e);
    req_access = A_LBU; req_addr = 32'h100; req_wdata = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, 32'hBEEF3456);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1 req_valid = 1'b0;
    if (!ok) fail("stall_accept_timeout");
    wait_done(d0 + 2);

    // Reset during SB CAPTURE: write suppressed, outputs return to reset values
    send(A_SB, 32'h103, 32'h00000055);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_ren) begin ok = 1; break; end
    end
    if (!ok) fail("abort_ren_timeout");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b0;
    issue(A_LW,  32'h100, 32'h0, 32'hBEEF3456, 1'b0, 3, 1, 0, 32'h0, 0);
    issue(A_LBU, 32'h103, 32'h0, 32'h000000BE, 1'b0, 3, 1, 0, 32'h0, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) fail("responses_outstanding");
    if (wq.size() != 0) fail("writes_outstanding");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
